// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-wide data memory.
// Sub-word stores are read-modify-write; the pipeline stalls until done.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic              misaligned,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_write,
    output logic              mem_write,
    input  logic [31:0]       mem_data_read
);

    typedef enum logic [2:0] {IDLE, RD, RD_CAP, WR, FIN} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t             state, state_next;
    logic               write_q, signed_q, err_q;
    logic [1:0]         size_q, off_q;
    logic [31:0]        wdata_q, wbuf;
    logic [ADDR_W-1:0]  addr_q;
    logic               bad_req, word_store;
    logic [4:0]         lane_shift;
    logic [31:0]        lane_data, load_fmt, lane_mask, merged;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2]};

    assign bad_req = (req_size == 2'b11)
                  || (req_size == SIZE_HALF && req_addr[0])
                  || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
    assign word_store = req_write && (req_size == SIZE_WORD);

    // Lane extraction and merge work on the latched byte offset only.
    assign lane_shift = {off_q, 3'b000};
    assign lane_data  = mem_data_read >> lane_shift;

    always_comb begin
        load_fmt  = mem_data_read;
        lane_mask = 32'hFFFF_FFFF;
        case (size_q)
            SIZE_BYTE: begin
                load_fmt  = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
                lane_mask = 32'h0000_00FF << lane_shift;
            end
            SIZE_HALF: begin
                load_fmt  = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
                lane_mask = 32'h0000_FFFF << lane_shift;
            end
            default: ;
        endcase
        merged = (mem_data_read & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) begin
                if (bad_req)         state_next = FIN;
                else if (word_store) state_next = WR;
                else                 state_next = RD;
            end
            RD:      state_next = RD_CAP;
            RD_CAP:  state_next = write_q ? WR : FIN;
            WR:      state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            off_q    <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            wbuf     <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q   <= req_addr[ADDR_W+1:2];
                    off_q    <= req_addr[1:0];
                    size_q   <= req_size;
                    write_q  <= req_write;
                    signed_q <= req_signed;
                    wdata_q  <= req_wdata;
                    err_q    <= bad_req;
                    if (word_store && !bad_req) wbuf <= req_wdata;
                end
                RD_CAP: begin
                    if (write_q) wbuf  <= merged;
                    else         rdata <= load_fmt;
                end
                FIN:     err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Strobe decoded from state so an asynchronous reset drops it immediately.
    assign mem_write      = (state == WR);
    assign mem_address    = addr_q;
    assign mem_data_write = wbuf;
    assign done           = (state == FIN);
    assign misaligned     = (state == FIN) && err_q;
    assign stall          = req_valid && !done;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: word-array memory plus a
// byte-lane reference model with a per-cycle compare process.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, misaligned;
    logic [31:0] rdata, mem_data_write, mem_data_read;
    logic [9:0]  mem_address;
    logic        mem_write;

    mem_access_unit #(.ADDR_W(10)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .misaligned(misaligned), .rdata(rdata),
        .mem_address(mem_address), .mem_data_write(mem_data_write),
        .mem_write(mem_write), .mem_data_read(mem_data_read)
    );

    always #5 clock = ~clock;

    // Data memory: writes on posedge, read data returned on negedge.
    logic [31:0] mem [0:1023];
    logic        mem_init, bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;
    int          wr_count = 0;

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= i;
        end else if (mem_write) begin
            mem[mem_address] <= mem_data_write;
            wr_count <= wr_count + 1;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    always @(negedge clock) mem_data_read <= mem[mem_address];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference model state (owned by the stimulus process).
    logic [31:0] ref_mem [0:1023];
    logic [31:0] model_rdata;
    int          exp_lat, exp_wcyc;
    logic        exp_err;
    logic [9:0]  exp_waddr;
    logic [31:0] exp_wword;
    int          req_id = 0;

    // Compare process state.
    int          seen_id = 0, done_id = 0, cyc = 0;
    logic        busy = 1'b0;

    function automatic logic [31:0] model_load(input logic [31:0] word, input int off,
                                               input logic [1:0] size, input logic sgn);
        logic [31:0] v;
        v = word >> (8 * off);
        if (size == 2'b00) begin
            v = v & 32'hFF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = v & 32'hFFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input int off,
                                                input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        r = word;
        for (int k = 0; k < n; k++) r[8*(off+k) +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // Drive a request this cycle and fold its effect into the model.
    task automatic start_req(input logic w, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] a, input logic [31:0] wd);
        int off;
        logic [9:0] widx;
        off  = int'(a[1:0]);
        widx = a[11:2];
        exp_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        if (exp_err)         exp_lat = 2;
        else if (!w)         exp_lat = 4;
        else if (sz == 2'b10) exp_lat = 3;
        else                 exp_lat = 5;
        exp_wcyc  = (w && !exp_err) ? exp_lat - 1 : 0;
        exp_waddr = widx;
        exp_wword = 32'h0;
        if (!exp_err) begin
            if (w) begin
                exp_wword     = model_store(ref_mem[widx], off, sz, wd);
                ref_mem[widx] = exp_wword;
            end else begin
                model_rdata = model_load(ref_mem[widx], off, sz, sgn);
            end
        end
        req_write = w; req_size = sz; req_signed = sgn; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        req_id++;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && done_id != req_id; i++) @(posedge clock);
        check("timeout", done_id, req_id);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] a, input logic [31:0] wd);
        @(posedge clock); #1;
        start_req(w, sz, sgn, a, wd);
        wait_req();
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        ref_mem[a] = d;
        @(posedge clock); #1;
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(posedge clock); #1;
        bd_we = 1'b0;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (seen_id != req_id) begin
                seen_id = req_id;
                cyc     = 1;
                busy    = 1'b1;
            end
            if (busy) begin
                check("stall", stall, cyc < exp_lat);
                check("done", done, cyc == exp_lat);
                check("mem_write", mem_write, cyc == exp_wcyc);
                if (cyc == exp_wcyc) begin
                    check("wr_addr", mem_address, exp_waddr);
                    check("wr_data", mem_data_write, exp_wword);
                end
                if (cyc == exp_lat) begin
                    check("misaligned", misaligned, exp_err);
                    check("rdata", rdata, model_rdata);
                    busy    = 1'b0;
                    done_id = req_id;
                end else begin
                    cyc++;
                end
            end else begin
                check("idle_mem_write", mem_write, 1'b0);
                check("idle_done", done, 1'b0);
            end
        end
    end

    initial begin
        int wr_before;
        reset = 1'b1; mem_init = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        model_rdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = i;
        exp_lat = 0; exp_wcyc = 0; exp_err = 1'b0; exp_waddr = '0; exp_wword = '0;
        @(posedge clock); @(posedge clock); #1 mem_init = 1'b0;
        @(negedge clock);
        check("rst_rdata", rdata, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_address", mem_address, 10'h0);
        check("rst_stall", stall, 1'b0);
        @(posedge clock); #1 reset = 1'b0;

        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("lit_word_store", mem[4], 32'hDEADBEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lit_word_load", rdata, 32'hDEADBEEF);

        poke(10'd4, 32'h11223344);
        run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA);
        check("lit_byte_store", mem[4], 32'h1122AA44);

        poke(10'd5, 32'h0000F080);
        run_req(1'b0, 2'b00, 1'b1, 32'h14, 32'h0);
        check("lit_lb_signed", rdata, 32'hFFFFFF80);
        run_req(1'b0, 2'b00, 1'b0, 32'h14, 32'h0);
        check("lit_lb_unsigned", rdata, 32'h00000080);
        run_req(1'b0, 2'b01, 1'b1, 32'h14, 32'h0);
        check("lit_lh_signed", rdata, 32'hFFFFF080);

        run_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000BEEF);
        check("lit_half_store", mem[5], 32'hBEEFF080);
        run_req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0);
        check("lit_lhu_hi", rdata, 32'h0000BEEF);
        run_req(1'b0, 2'b00, 1'b1, 32'h17, 32'h0);
        check("lit_lb_lane3", rdata, 32'hFFFFFFBE);
        run_req(1'b0, 2'b10, 1'b1, 32'h14, 32'h0);
        check("lit_lw_signed_ign", rdata, 32'hBEEFF080);
        run_req(1'b0, 2'b00, 1'b0, 32'hF000_0014, 32'h0);
        check("lit_high_addr_ign", rdata, 32'h00000080);

        run_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        run_req(1'b1, 2'b01, 1'b0, 32'h15, 32'h12345678);
        run_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        check("lit_misaligned_rdata", rdata, 32'h00000080);
        check("lit_misaligned_mem5", mem[5], 32'hBEEFF080);

        // Reset in the middle of a read-modify-write: nothing may be written.
        @(posedge clock); #1;
        wr_before = wr_count;
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h19; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clock); @(posedge clock); #2;
        reset = 1'b1;
        #1;
        model_rdata = '0;
        check("rmw_rst_mem_write", mem_write, 1'b0);
        check("rmw_rst_rdata", rdata, 32'h0);
        check("rmw_rst_mem_address", mem_address, 10'h0);
        check("rmw_rst_wdata", mem_data_write, 32'h0);
        check("rmw_rst_done", done, 1'b0);
        check("rmw_rst_misaligned", misaligned, 1'b0);
        check("rmw_rst_stall", stall, 1'b1);
        @(posedge clock); @(posedge clock); #1;
        check("rmw_rst_no_write", wr_count, wr_before);
        check("rmw_rst_mem6", mem[6], 32'h6);
        reset = 1'b0;
        start_req(1'b1, 2'b00, 1'b0, 32'h19, 32'h55);
        wait_req();
        check("lit_rmw_restart", mem[6], 32'h00005506);

        @(posedge clock); #1;
        for (int i = 0; i < 16; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data memory port, in the MEM stage of the MIPS/DLX pipeline.
- Takes load/store requests from the pipeline: byte, halfword or word; signed or unsigned loads.
- Drives the word-wide data memory (10-bit word address, single mem_write strobe, read data returned on the memory's negedge).
- Sub-word stores use read-modify-write. The pipeline is stalled until the access completes.

Parameters:
- ADDR_W, 10, word-address width driven to data memory; byte address bits [ADDR_W+1:2] are used, higher bits ignored.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present; held stable by the pipeline until done.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- stall  out  1  combinational: req_valid && !done.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  one-cycle error pulse, coincident with done.
- rdata  out  32  formatted load result; registered and held.
- mem_address  out  ADDR_W  word address to data memory.
- mem_data_write  out  32  write word to data memory.
- mem_write  out  1  write strobe to data memory.
- mem_data_read  in  32  read word from data memory; valid by the posedge after the address is driven.

Behaviour:
- Byte lanes are little-endian within the word: offset k occupies bits [8k+7:8k]; a halfword at offset 2 occupies bits [31:16].
- Moore FSM. States: IDLE, RD, RD_CAP, WR, FIN. Memory-side outputs are registered/decoded from state and the latched request only.
- IDLE
  - mem_write = 0.
  - On req_valid: latch req_*.
  - Misaligned or reserved request (half with addr[0]=1, word with addr[1:0]≠0, or size=11): go to FIN with the error flag set; no memory access.
  - Word store: go to WR, wbuf = req_wdata.
  - Otherwise (any load, or byte/half store): go to RD.
- RD: mem_address = latched word address, mem_write = 0 → RD_CAP.
- RD_CAP: sample mem_data_read.
  - Load: extract the addressed lane, sign- or zero-extend, write into rdata → FIN.
  - Sub-word store: wbuf = read word with only the addressed lane(s) replaced by req_wdata low bits → WR.
- WR: mem_write = 1 for exactly one cycle; mem_address is the latched address; mem_data_write = wbuf → FIN.
- FIN: done = 1; misaligned = error flag → IDLE. The error flag clears on leaving FIN.
- Latency (cycles from the IDLE accept cycle to done, inclusive):
  - load: 4
  - word store: 3
  - sub-word store: 5
  - misaligned: 2
- stall is high from the accept cycle through the cycle before FIN, and low in FIN, so the pipeline advances at the posedge ending FIN. The same request is never re-accepted.
- req_valid dropping or req_* changing mid-transaction is ignored; the latched request completes.
- Word loads ignore req_signed. Stores never modify rdata. Misaligned requests leave rdata unchanged.
- mem_write is never asserted outside WR. RD and WR are never active in the same cycle.
- Reset (asserted anytime, including mid-RMW):
  - state = IDLE, mem_write = 0 immediately (asynchronous).
  - done = 0, misaligned = 0, rdata = 0, mem_address = 0, mem_data_write = 0, wbuf = 0.
  - An interrupted store either completed its WR cycle or did not write at all; no partial word is written.
  - After reset release, a still-asserted req_valid is accepted as a new request.

Test Plan:
- Bench memory model: word i = i at start. Word store addr 0x10, data 0xDEADBEEF → mem_write pulse at word 4 in cycle 2. Then a word load from 0x10 → rdata = 0xDEADBEEF, done in cycle 4, stall high for 3 cycles.
- Byte store addr 0x11, data 0x000000AA over word 4 = 0x11223344 → RD, then WR writes 0x1122AA44; exactly one mem_write cycle; done at cycle 5.
- Word 5 = 0x0000F080. Byte load addr 0x14: signed → 0xFFFFFF80, unsigned → 0x00000080. Half load addr 0x14 signed → 0xFFFFF080.
- Half store addr 0x16, data 0x0000BEEF over 0x0000F080 → word 5 = 0xBEEFF080. Then unsigned half load at 0x16 → 0x0000BEEF.
- Word load addr 0x13 and half store addr 0x15 → misaligned = done = 1 at cycle 2; no mem_write; memory and rdata unchanged.
- Sub-word store with reset asserted during RD_CAP → mem_write never rises; target word unchanged; all outputs 0. After release, the held request restarts and completes normally.
